// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler owning HI/LO.
// The result is computed at the accept edge into pending registers, then
// held for a fixed number of cycles before committing to HI/LO, so the
// pipeline timing matches a real iterative unit.
// Optional MADD/MADDU accumulate is enabled by defining MD_MADD_EN.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   p_hi, p_lo;

    logic [63:0]   prod_s, prod_u;
    logic [31:0]   bs_div, bu_div;
    logic [31:0]   quo_s, rem_s, quo_u, rem_u;
    logic          div_zero, div_ovf;

    logic [63:0]   res;     // pending {HI,LO} for the op being accepted
    logic [CW-1:0] cyc_ld;  // busy length for the op being accepted
    logic          go;      // op launches a multi-cycle run

    assign busy     = (state == S_RUN);
    assign md_stall = md_use_D & (busy | start);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Corner cases are patched in afterwards; the divisor is forced to 1
    // for them so the divider never sees /0 or MIN/-1.
    assign div_zero = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign bs_div   = (div_zero || div_ovf) ? 32'd1 : B;
    assign bu_div   = div_zero ? 32'd1 : B;
    assign quo_s    = $signed(A) / $signed(bs_div);
    assign rem_s    = $signed(A) % $signed(bs_div);
    assign quo_u    = A / bu_div;
    assign rem_u    = A % bu_div;

    // Select the pending result and run length for the incoming op.
    always_comb begin
        res    = 64'd0;
        cyc_ld = '0;
        go     = 1'b0;
        case (op)
            3'd0: begin
                res = prod_s; cyc_ld = CW'(MULT_CYCLES); go = 1'b1;
            end
            3'd1: begin
                res = prod_u; cyc_ld = CW'(MULT_CYCLES); go = 1'b1;
            end
            3'd2: begin
                if (div_zero)     res = {A, 32'hFFFF_FFFF};
                else if (div_ovf) res = {32'd0, 32'h8000_0000};
                else              res = {rem_s, quo_s};
                cyc_ld = CW'(DIV_CYCLES); go = 1'b1;
            end
            3'd3: begin
                if (div_zero) res = {A, 32'hFFFF_FFFF};
                else          res = {rem_u, quo_u};
                cyc_ld = CW'(DIV_CYCLES); go = 1'b1;
            end
`ifdef MD_MADD_EN
            3'd6: begin
                res = {HI, LO} + prod_s; cyc_ld = CW'(MULT_CYCLES); go = 1'b1;
            end
            3'd7: begin
                res = {HI, LO} + prod_u; cyc_ld = CW'(MULT_CYCLES); go = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // FSM, countdown, pending capture and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (go) begin
                            {p_hi, p_lo} <= res;
                            cnt          <= cyc_ld;
                            state        <= S_RUN;
                        end else if (op == 3'd4) begin
                            HI <= A;
                        end else if (op == 3'd5) begin
                            LO <= A;
                        end
                    end
                end
                default: begin
                    // start is ignored here; only the commit touches HI/LO
                    if (cnt == CW'(1)) begin
                        HI    <= p_hi;
                        LO    <= p_lo;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected {HI,LO} pushed at issue,
// popped and compared when the unit goes idle again.
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        md_use_D = 1'b0;
    logic        busy, md_stall;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .md_use_D(md_use_D), .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int op_cycles(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return MC;
            3'd2, 3'd3: return DC;
`ifdef MD_MADD_EN
            3'd6, 3'd7: return MC;
`endif
            default:    return 0;
        endcase
    endfunction

    // Reference model for the random multiply/divide mix.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        int     q, r;
        case (o)
            3'd0: begin sp = longint'(int'(x)) * longint'(int'(y)); return sp; end
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = int'(x) / int'(y);
                r = int'(x) % int'(y);
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input logic use_d);
        int n, cyc;
        logic [63:0] e;
        n = op_cycles(o);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; md_use_D = use_d;
        sb.push_back(exp);
        #1;
        if (use_d) chk({tag, "_stall_start"}, 64'(md_stall), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 200) begin
            cyc++;
            if (use_d) chk({tag, "_stall_busy"}, 64'(md_stall), 64'd1);
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
        if (use_d) chk({tag, "_stall_fall"}, 64'(md_stall), 64'd0);
        e = sb.pop_front();
        chk({tag, "_hilo"}, {HI, LO}, e);
        md_use_D = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] e;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        md_use_D = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_stall", 64'(md_stall), 64'd0);
        md_use_D = 1'b0;

        // directed cases
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b1);
        run_op("divu_7_2", 3'd3, 32'd7, 32'd2, {32'd1, 32'd3}, 1'b0);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_op("div_by0", 3'd2, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b0);
        run_op("divu_by0", 3'd3, 32'd9, 32'd0, {32'd9, 32'hFFFF_FFFF}, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
        run_op("divu_big", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 1'b0);
        run_op("mthi", 3'd4, 32'h1234, 32'd0, {32'h1234, 32'd0}, 1'b0);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'd1}, 1'b0);

        // MTLO issued while a MULT is running must be ignored
        run_op("mthi0", 3'd4, 32'd0, 32'd0, {32'd0, 32'd1}, 1'b0);
        run_op("mtlo0", 3'd5, 32'd0, 32'd0, 64'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        sb.push_back({32'd0, 32'd12});
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 200) begin
            cyc++;
            if (cyc == 2) begin
                start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            if (cyc == 3) chk("mtlo_run_lo_hold", {HI, LO}, 64'd0);
            @(negedge clk);
        end
        start = 1'b0;
        chk("mtlo_run_busy_cycles", 64'(cyc), 64'(MC));
        e = sb.pop_front();
        chk("mtlo_run_hilo", {HI, LO}, e);

        // random multiply/divide mix against the reference model
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (ro >= 3'd2 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, ref_md(ro, ra, rb), 1'b0);
        end

        // MADD: accumulate when enabled, no-op otherwise
        run_op("madd_hi", 3'd4, 32'd0, 32'd0, {32'd0, LO}, 1'b0);
        run_op("madd_lo", 3'd5, 32'd10, 32'd0, {32'd0, 32'd10}, 1'b0);
`ifdef MD_MADD_EN
        run_op("madd", 3'd6, 32'd2, 32'd3, {32'd0, 32'd16}, 1'b0);
        run_op("maddu", 3'd7, 32'hFFFF_FFFF, 32'd2, {32'd2, 32'd14}, 1'b0);
`else
        run_op("madd", 3'd6, 32'd2, 32'd3, {32'd0, 32'd10}, 1'b0);
        run_op("maddu", 3'd7, 32'hFFFF_FFFF, 32'd2, {32'd0, 32'd10}, 1'b0);
`endif

        // reset in the middle of a DIV discards the pending result
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 3) begin
            cyc++;
            if (cyc < 3) @(negedge clk);
        end
        chk("rstmid_running", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_hilo", {HI, LO}, 64'd0);
        repeat (12) @(negedge clk);
        chk("rstmid_no_commit", {HI, LO}, 64'd0);
        chk("rstmid_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
